// File: rtl/div_in_collector.sv
// Collects eight pushed bytes into a dividend/divisor pair, then spends one cycle
// deriving magnitudes, sign flags and divisor leading zeros before handing off to the SRT divider.
module div_in_collector #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       data_in,
    input  logic             push_in,
    input  logic             sign,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] dividend,
    output logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] abs_dividend,
    output logic [WIDTH-1:0] abs_divisor,
    output logic             q_neg,
    output logic             r_neg,
    output logic             op_signed,
    output logic             div_zero,
    output logic [5:0]       dvsr_lz,
    output logic             overflow
);
    localparam int BYTES = WIDTH / 8;
    localparam int LANES = 2 * BYTES;
    localparam int CNT_W = $clog2(LANES);

    typedef enum logic [1:0] {COLLECT, CALC, HOLD} state_t;

    state_t             state_reg, state_next;
    logic               push_prev_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [WIDTH-1:0]   dividend_reg, divisor_reg;
    logic [WIDTH-1:0]   abs_dividend_reg, abs_divisor_reg;
    logic               q_neg_reg, r_neg_reg, op_signed_reg, div_zero_reg, overflow_reg;
    logic [5:0]         dvsr_lz_reg;

    logic               push_edge, accept, last_byte;
    logic [LANES-1:0]   lane_we;
    logic [WIDTH-1:0]   abs_dividend_next, abs_divisor_next;
    logic               div_zero_next;
    logic [5:0]         dvsr_lz_next;

    // A held-high strobe counts once: only a low-to-high step is a push.
    assign push_edge = push_in & ~push_prev_reg;
    assign accept    = (state_reg == COLLECT) && push_edge;
    assign last_byte = (cnt_reg == CNT_W'(LANES - 1));

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign lane_we[gi] = accept && (cnt_reg == CNT_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) state_reg <= COLLECT;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            COLLECT: if (accept && last_byte) state_next = CALC;
            CALC:    state_next = HOLD;
            HOLD:    if (out_ready) state_next = COLLECT;
            default: state_next = COLLECT;
        endcase
    end

    // Magnitudes: -2^(WIDTH-1) negates to itself, which is the correct unsigned magnitude.
    always_comb begin
        abs_dividend_next = (op_signed_reg && dividend_reg[WIDTH-1])
                          ? (~dividend_reg + WIDTH'(1)) : dividend_reg;
        abs_divisor_next  = (op_signed_reg && divisor_reg[WIDTH-1])
                          ? (~divisor_reg + WIDTH'(1)) : divisor_reg;
        div_zero_next     = (divisor_reg == '0);
        dvsr_lz_next      = 6'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (abs_divisor_next[i]) dvsr_lz_next = 6'(WIDTH - 1 - i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            push_prev_reg    <= 1'b0;
            cnt_reg          <= '0;
            dividend_reg     <= '0;
            divisor_reg      <= '0;
            abs_dividend_reg <= '0;
            abs_divisor_reg  <= '0;
            q_neg_reg        <= 1'b0;
            r_neg_reg        <= 1'b0;
            op_signed_reg    <= 1'b0;
            div_zero_reg     <= 1'b0;
            dvsr_lz_reg      <= 6'(WIDTH);
            overflow_reg     <= 1'b0;
        end else begin
            push_prev_reg <= push_in;
            if (push_edge && state_reg != COLLECT) overflow_reg <= 1'b1;
            if (accept) begin
                cnt_reg <= last_byte ? '0 : cnt_reg + CNT_W'(1);
                if (last_byte) op_signed_reg <= sign;
            end
            for (int i = 0; i < BYTES; i++) begin
                if (lane_we[i])         dividend_reg[WIDTH-1-8*i -: 8] <= data_in;
                if (lane_we[BYTES + i]) divisor_reg[WIDTH-1-8*i -: 8]  <= data_in;
            end
            if (state_reg == CALC) begin
                abs_dividend_reg <= abs_dividend_next;
                abs_divisor_reg  <= abs_divisor_next;
                div_zero_reg     <= div_zero_next;
                dvsr_lz_reg      <= dvsr_lz_next;
                q_neg_reg        <= op_signed_reg & (dividend_reg[WIDTH-1] ^ divisor_reg[WIDTH-1])
                                    & ~div_zero_next;
                r_neg_reg        <= op_signed_reg & dividend_reg[WIDTH-1];
            end
        end
    end

    assign out_valid    = (state_reg == HOLD);
    assign dividend     = dividend_reg;
    assign divisor      = divisor_reg;
    assign abs_dividend = abs_dividend_reg;
    assign abs_divisor  = abs_divisor_reg;
    assign q_neg        = q_neg_reg;
    assign r_neg        = r_neg_reg;
    assign op_signed    = op_signed_reg;
    assign div_zero     = div_zero_reg;
    assign dvsr_lz      = dvsr_lz_reg;
    assign overflow     = overflow_reg;
endmodule

// File: tb/tb_div_in_collector.sv
// Scoreboard bench for div_in_collector: stimulus enqueues model results,
// a negedge monitor pops and compares whenever out_valid presents an operand set.
module tb_div_in_collector;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  data_in = 8'h00;
    logic        push_in = 1'b0;
    logic        sign = 1'b0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [31:0] dividend, divisor, abs_dividend, abs_divisor;
    logic        q_neg, r_neg, op_signed, div_zero, overflow;
    logic [5:0]  dvsr_lz;

    div_in_collector #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .push_in(push_in), .sign(sign),
        .out_ready(out_ready), .out_valid(out_valid), .dividend(dividend), .divisor(divisor),
        .abs_dividend(abs_dividend), .abs_divisor(abs_divisor), .q_neg(q_neg), .r_neg(r_neg),
        .op_signed(op_signed), .div_zero(div_zero), .dvsr_lz(dvsr_lz), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] dvd, dvs, adv, ads;
        logic        qn, rn, sg, dz;
        logic [5:0]  lz;
        int          cap;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   xfer_cnt = 0;
    int   ready_mode = 2;  // 0 random, 1 low, 2 high

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    // Reference: operands from byte order, magnitudes and flags from signed arithmetic.
    function automatic exp_t model(input logic [63:0] ops, input logic sg);
        exp_t e;
        longint unsigned d, v, ad, av;
        d  = longint'(ops[63:32]);
        v  = longint'(ops[31:0]);
        ad = (sg && d >= 64'h8000_0000) ? 64'h1_0000_0000 - d : d;
        av = (sg && v >= 64'h8000_0000) ? 64'h1_0000_0000 - v : v;
        e.dvd = ops[63:32];
        e.dvs = ops[31:0];
        e.adv = ad[31:0];
        e.ads = av[31:0];
        e.sg  = sg;
        e.dz  = (v == 0);
        e.lz  = (av == 0) ? 6'd32 : 6'(32 - $clog2(av + 1));
        e.rn  = sg && (d >= 64'h8000_0000);
        e.qn  = sg && ((d >= 64'h8000_0000) != (v >= 64'h8000_0000)) && (v != 0);
        e.cap = 0;
        return e;
    endfunction

    // Out_ready driver: random, forced low or forced high.
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       out_ready = ($urandom_range(0, 2) == 0);
            1:       out_ready = 1'b0;
            default: out_ready = 1'b1;
        endcase
    end

    // Monitor: compare on first HOLD cycle, then stability, then drop after transfer.
    exp_t cur;
    bit   seen = 0;
    bit   drop_chk = 0;
    always @(negedge clk) begin
        if (rst) begin
            seen = 0;
            drop_chk = 0;
        end else begin
            if (drop_chk) begin
                chk("valid_drop_after_xfer", {31'd0, out_valid}, 32'd0);
                drop_chk = 0;
                seen = 0;
            end else if (out_valid) begin
                if (!seen) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_valid: got out_valid 1 expected no pending set");
                    end else begin
                        cur = sb_q.pop_front();
                        chk("latency", cyc, cur.cap + 1);
                        chk("dividend", dividend, cur.dvd);
                        chk("divisor", divisor, cur.dvs);
                        chk("abs_dividend", abs_dividend, cur.adv);
                        chk("abs_divisor", abs_divisor, cur.ads);
                        chk("q_neg", {31'd0, q_neg}, {31'd0, cur.qn});
                        chk("r_neg", {31'd0, r_neg}, {31'd0, cur.rn});
                        chk("op_signed", {31'd0, op_signed}, {31'd0, cur.sg});
                        chk("div_zero", {31'd0, div_zero}, {31'd0, cur.dz});
                        chk("dvsr_lz", {26'd0, dvsr_lz}, {26'd0, cur.lz});
                    end
                    seen = 1;
                end else begin
                    chk("hold_stable_dividend", dividend, cur.dvd);
                    chk("hold_stable_abs_divisor", abs_divisor, cur.ads);
                end
                if (out_ready) begin
                    xfer_cnt++;
                    drop_chk = 1;
                end
            end else begin
                seen = 0;
            end
        end
    end

    // All stimulus tasks start and end 1 time unit after a rising edge.
    task automatic send_set(input logic [63:0] ops, input logic sg, input int len);
        exp_t e;
        for (int b = 0; b < 8; b++) begin
            data_in = ops[63 - 8*b -: 8];
            sign    = sg;
            push_in = 1'b1;
            @(posedge clk); #1;
            if (b == 7) begin
                e = model(ops, sg);
                e.cap = cyc;
                sb_q.push_back(e);
            end
            repeat (len - 1) begin @(posedge clk); #1; end
            push_in = 1'b0;
            data_in = $urandom_range(0, 255);
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_xfer(input int target);
        int n;
        n = 0;
        while (xfer_cnt < target && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (xfer_cnt < target) begin
            checks++;
            errors++;
            $display("FAIL xfer_timeout: got %0d transfers expected %0d", xfer_cnt, target);
        end
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("valid_seen", {31'd0, out_valid}, 32'd1);
    endtask

    int xt = 0;
    initial begin
        logic [31:0] d, v;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        chk("rst_dividend", dividend, 32'd0);
        chk("rst_abs_divisor", abs_divisor, 32'd0);
        chk("rst_dvsr_lz", {26'd0, dvsr_lz}, 32'd32);
        chk("rst_flags", {28'd0, q_neg, r_neg, op_signed, div_zero}, 32'd0);

        ready_mode = 2;
        send_set(64'h12345678_00000100, 1'b0, 1); xt++; wait_xfer(xt);
        send_set(64'hFFFFFF9C_00000007, 1'b1, 1); xt++; wait_xfer(xt);
        send_set(64'h80000000_00000000, 1'b1, 1); xt++; wait_xfer(xt);
        chk("no_overflow_yet", {31'd0, overflow}, 32'd0);

        // Backpressure: pushes during HOLD are dropped and flagged.
        ready_mode = 1;
        send_set(64'h0000F000_FFFFFFFD, 1'b1, 1);
        wait_valid();
        send_set_partial_drop();
        repeat (6) begin @(posedge clk); #1; end
        chk("bp_overflow", {31'd0, overflow}, 32'd1);
        chk("bp_still_valid", {31'd0, out_valid}, 32'd1);
        ready_mode = 2;
        xt++; wait_xfer(xt);
        ready_mode = 0;
        send_set(64'hDEADBEEF_00000003, 1'b0, 1); xt++; wait_xfer(xt);

        // Long pushes: each held level counts once.
        send_set(64'h7FFFFFFF_80000000, 1'b1, 5); xt++; wait_xfer(xt);

        // Reset mid-collection discards partial bytes; first post-release push is byte 0.
        for (int b = 0; b < 3; b++) begin
            data_in = 8'h55; push_in = 1'b1;
            @(posedge clk); #1;
            push_in = 1'b0;
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        send_set(64'hA1B2C3D4_000000FF, 1'b1, 1); xt++; wait_xfer(xt);
        chk("rst_clears_overflow", {31'd0, overflow}, 32'd0);

        for (int k = 0; k < 20; k++) begin
            d = $urandom;
            v = $urandom >> $urandom_range(0, 31);
            case ($urandom_range(0, 4))
                0: v = 32'd0;
                1: d = 32'h8000_0000;
                2: v = ~v;
                default: ;
            endcase
            send_set({d, v}, 1'($urandom_range(0, 1)), $urandom_range(1, 3));
            xt++;
            wait_xfer(xt);
        end

        repeat (4) @(posedge clk);
        #1;
        chk("scoreboard_empty", sb_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Two push edges while the set is held; bytes must not disturb the outputs.
    task automatic send_set_partial_drop();
        for (int b = 0; b < 2; b++) begin
            data_in = (b == 0) ? 8'hAA : 8'hBB;
            push_in = 1'b1;
            @(posedge clk); #1;
            push_in = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
